// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and helpers for the pipeline register chain
package pipe_pkg;
  localparam int MAX_DEPTH = 8;
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic logic [3:0] popcount(input logic [MAX_DEPTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < MAX_DEPTH; i++) popcount += {3'd0, v[i]};
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid+data register with flush > hold > bubble > load priority
module pipe_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             hold,
  input  logic             bubble,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  always_comb begin
    valid_d = flush ? 1'b0 : hold ? valid_q : bubble ? 1'b0 : in_valid;
    data_d  = flush ? '0 : hold ? data_q : (bubble || !in_valid) ? '0 : in_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage pipeline register with stall, bubble, flush and occupancy.
// Define PIPE_PERF_CNT_EN to build the saturating stall/flush performance counters.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic [DEPTH-1:0]           stall,
  input  logic [DEPTH-1:0]           flush,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [occ_w(DEPTH)-1:0]    occupancy,
  output logic [CNT_W-1:0]           stall_cycles,
  output logic [CNT_W-1:0]           flush_events
);
  localparam int OCC_W = occ_w(DEPTH);
  logic [DEPTH-1:0] hold, bubble, src_valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic [WIDTH-1:0] src_data [DEPTH];
  // a stall anywhere downstream freezes every upstream stage
  always_comb begin
    hold   = '0;
    bubble = '0;
    hold[DEPTH-1] = stall[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) hold[i] = stall[i] | hold[i+1];
    for (int i = 1; i < DEPTH; i++) bubble[i] = hold[i-1];
  end
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_valid[k] = in_valid;
      assign src_data[k]  = in_data;
    end else begin : g_body
      assign src_valid[k] = stage_valid[k-1];
      assign src_data[k]  = data[k-1];
    end
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush[k]),
      .hold     (hold[k]),
      .bubble   (bubble[k]),
      .in_valid (src_valid[k]),
      .in_data  (src_data[k]),
      .valid    (stage_valid[k]),
      .data     (data[k])
    );
  end
  assign in_ready  = !hold[0];
  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign occupancy = OCC_W'(popcount(MAX_DEPTH'(stage_valid)));
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d, flush_events_q, flush_events_d;
  always_comb begin
    stall_cycles_d = (in_valid && !in_ready && !(&stall_cycles_q)) ? stall_cycles_q + 1'b1 : stall_cycles_q;
    flush_events_d = (|(flush & stage_valid) && !(&flush_events_q)) ? flush_events_q + 1'b1 : flush_events_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: scoreboard bench for a 3-deep chain plus a 1-deep chain with 2-bit counters
module tb_pipe_reg_chain;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid;
  logic [63:0] a_in_data = '0, a_out_data;
  logic [2:0]  a_stall = '0, a_flush = '0, a_stage_valid;
  logic [1:0]  a_occ;
  logic [31:0] a_sc, a_fe;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid;
  logic [63:0] b_in_data = '0, b_out_data;
  logic [0:0]  b_stall = '0, b_flush = '0, b_stage_valid, b_occ;
  logic [1:0]  b_sc, b_fe;

  pipe_reg_chain #(.WIDTH(64), .DEPTH(3), .CNT_W(32)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .stall(a_stall), .flush(a_flush), .out_valid(a_out_valid), .out_data(a_out_data),
    .stage_valid(a_stage_valid), .occupancy(a_occ), .stall_cycles(a_sc), .flush_events(a_fe));

  pipe_reg_chain #(.WIDTH(64), .DEPTH(1), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .stall(b_stall), .flush(b_flush), .out_valid(b_out_valid), .out_data(b_out_data),
    .stage_valid(b_stage_valid), .occupancy(b_occ), .stall_cycles(b_sc), .flush_events(b_fe));

  int checks = 0;
  int errors = 0;
  logic [63:0] sb [$];

  // entries are checked as they leave the last stage of chain a
  task automatic tick();
    logic acc;
    logic [63:0] d, e;
    #1;
    acc = a_in_valid && a_in_ready && rst_n;
    d = a_in_data;
    if (rst_n && a_out_valid && !a_stall[2] && !a_flush[2]) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow got %h expected nothing", a_out_data);
      end else begin
        e = sb.pop_front();
        if (a_out_data !== e) begin errors++; $display("FAIL sb_data got %h expected %h", a_out_data, e); end
      end
    end
    @(posedge clk); #1;
    if (!rst_n) sb.delete();
    else if (acc) sb.push_back(d);
  endtask

  task automatic load3(input logic [63:0] base);
    a_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin a_in_data = base + 64'(i); tick(); end
  endtask

  task automatic drain(input int n);
    a_in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL drain_empty got %0d expected 0", sb.size()); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_in_valid = 1'b1; a_in_data = '1; b_in_valid = 1'b1; b_in_data = '1;
    tick(); tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b expected 0", a_out_valid); end
    checks++; if (a_out_data !== 64'd0) begin errors++; $display("FAIL rst_out_data got %h expected 0", a_out_data); end
    checks++; if (a_stage_valid !== 3'b000) begin errors++; $display("FAIL rst_stage_valid got %b expected 000", a_stage_valid); end
    checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL rst_occ got %0d expected 0", a_occ); end
    checks++; if ({a_sc, a_fe} !== 64'd0) begin errors++; $display("FAIL rst_counters got %h expected 0", {a_sc, a_fe}); end
    checks++; if ({b_out_valid, b_out_data} !== 65'd0) begin errors++; $display("FAIL rst_b_out got %h expected 0", {b_out_valid, b_out_data}); end
    a_in_valid = 1'b0; b_in_valid = 1'b0; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    logic [1:0] peak;
    peak = '0;
    a_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_data = 64'hA + 64'(i); tick();
      if (a_occ > peak) peak = a_occ;
    end
    checks++; if ({a_out_valid, a_out_data} !== {1'b1, 64'hA}) begin errors++; $display("FAIL stream_latency got %b/%h expected 1/a", a_out_valid, a_out_data); end
    a_in_valid = 1'b0;
    tick(); checks++; if (a_out_data !== 64'hB) begin errors++; $display("FAIL stream_b got %h expected b", a_out_data); end
    tick(); checks++; if (a_out_data !== 64'hC) begin errors++; $display("FAIL stream_c got %h expected c", a_out_data); end
    checks++; if (peak !== 2'd3) begin errors++; $display("FAIL stream_peak_occ got %0d expected 3", peak); end
    drain(3);
  endtask

  task automatic test_stall_bubble();
    load3(64'hA);
    a_stall = 3'b010; a_in_valid = 1'b1; a_in_data = 64'hD;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b expected 0", a_in_ready); end
    tick();
    checks++; if ({a_out_valid, a_out_data} !== 65'd0) begin errors++; $display("FAIL stall_bubble got %b/%h expected 0/0", a_out_valid, a_out_data); end
    checks++; if (a_stage_valid !== 3'b011) begin errors++; $display("FAIL stall_hold1 got %b expected 011", a_stage_valid); end
    tick();
    checks++; if (a_stage_valid !== 3'b011) begin errors++; $display("FAIL stall_hold2 got %b expected 011", a_stage_valid); end
    a_stall = '0; a_in_valid = 1'b0;
    tick();
    checks++; if ({a_out_valid, a_out_data} !== {1'b1, 64'hB}) begin errors++; $display("FAIL stall_release got %b/%h expected 1/b", a_out_valid, a_out_data); end
    drain(3);
  endtask

  task automatic test_flush_over_stall();
    load3(64'h1);
    a_stall = 3'b100; a_flush = 3'b010; a_in_valid = 1'b1; a_in_data = 64'h4;
    tick();
    sb.delete(1);
    checks++; if (a_stage_valid !== 3'b101) begin errors++; $display("FAIL fos_stage_valid got %b expected 101", a_stage_valid); end
    checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL fos_occ got %0d expected 2", a_occ); end
    checks++; if (a_out_data !== 64'h1) begin errors++; $display("FAIL fos_out got %h expected 1", a_out_data); end
    a_flush = '0;
    tick();
    checks++; if (a_stage_valid !== 3'b101) begin errors++; $display("FAIL fos_bubble_held got %b expected 101", a_stage_valid); end
    a_stall = '0;
    drain(5);
  endtask

  task automatic test_depth1();
    logic [63:0] inst;
    inst = {32'h4, 32'hE3A01001};
    b_in_valid = 1'b1; b_in_data = inst;
    tick();
    checks++; if ({b_out_valid, b_out_data} !== {1'b1, inst}) begin errors++; $display("FAIL d1_load got %b/%h expected 1/%h", b_out_valid, b_out_data, inst); end
    b_stall = 1'b1; b_in_data = 64'hDEAD;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({b_in_ready, b_out_data} !== {1'b0, inst}) begin errors++; $display("FAIL d1_hold%0d got %b/%h expected 0/%h", i, b_in_ready, b_out_data, inst); end
    end
    checks++; if (b_sc !== (PERF ? 2'd3 : 2'd0)) begin errors++; $display("FAIL d1_stall_sat got %0d expected %0d", b_sc, PERF ? 3 : 0); end
    b_stall = 1'b0; b_flush = 1'b1;
    tick();
    checks++; if ({b_out_valid, b_out_data} !== 65'd0) begin errors++; $display("FAIL d1_flush got %b/%h expected 0/0", b_out_valid, b_out_data); end
    checks++; if (b_fe !== (PERF ? 2'd1 : 2'd0)) begin errors++; $display("FAIL d1_flush_cnt got %0d expected %0d", b_fe, PERF ? 1 : 0); end
    b_flush = 1'b0; b_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    load3(64'h70);
    a_stall = 3'b001;
    rst_n = 1'b0;
    tick();
    checks++; if ({a_stage_valid, a_occ, a_out_valid, a_out_data} !== 70'd0) begin errors++; $display("FAIL midrst_state got %b/%0d/%h expected 0", a_stage_valid, a_occ, a_out_data); end
    checks++; if ({a_sc, a_fe, b_sc, b_fe} !== 68'd0) begin errors++; $display("FAIL midrst_counters got %h expected 0", {a_sc, a_fe, b_sc, b_fe}); end
    rst_n = 1'b1; a_stall = '0; a_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_perf();
    a_in_valid = 1'b1;
    a_in_data = 64'h11; tick();
    a_in_data = 64'h22; tick();
    a_stall = 3'b100; a_in_data = 64'h33;
    for (int i = 0; i < 5; i++) tick();
    a_in_valid = 1'b0;
    a_flush = 3'b100; tick();
    a_flush = 3'b010; tick(); sb.delete(0);
    a_flush = 3'b001; tick(); sb.delete(0);
    a_flush = '0; a_stall = '0;
    checks++; if (a_sc !== (PERF ? 32'd5 : 32'd0)) begin errors++; $display("FAIL perf_stall got %0d expected %0d", a_sc, PERF ? 5 : 0); end
    checks++; if (a_fe !== (PERF ? 32'd2 : 32'd0)) begin errors++; $display("FAIL perf_flush got %0d expected %0d", a_fe, PERF ? 2 : 0); end
    checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL perf_occ got %0d expected 0", a_occ); end
    drain(3);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_bubble();
    test_flush_over_stall();
    test_depth1();
    test_reset_mid();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
